// File: rtl/l1_servo_pkg.sv
// rtl/l1_servo_pkg.sv - shared types, default addresses and threshold step rule for the L1 threshold servo
package l1_servo_pkg;

  localparam int THRESH_BITS = 18;

  localparam logic [12:0] SCALER_BASE = 13'h0800;
  localparam logic [12:0] THRESH_BASE = 13'h0000;
  localparam logic [12:0] UPDATE_ADDR = 13'h1000;

  typedef logic [THRESH_BITS-1:0] thresh_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_SCAL,
    S_CALC,
    S_WR_THR,
    S_NEXT,
    S_WR_UPD,
    S_ABORT
  } state_e;

  // Counts compare in 25 bits and threshold sums in THRESH_BITS+2 bits so no term can wrap.
  function automatic thresh_t servo_step(
    input thresh_t                thr,
    input logic [23:0]            cnt,
    input logic [23:0]            target,
    input logic [15:0]            band,
    input logic [THRESH_BITS+1:0] step,
    input thresh_t                tmin,
    input thresh_t                tmax
  );
    logic [24:0]            c25;
    logic [24:0]            t25;
    logic [24:0]            hi25;
    logic [24:0]            lo25;
    logic [THRESH_BITS+1:0] t_w;
    logic [THRESH_BITS+1:0] sum_w;
    logic [THRESH_BITS+1:0] diff_w;
    c25    = {1'b0, cnt};
    t25    = {1'b0, target};
    hi25   = t25 + {9'b0, band};
    lo25   = c25 + {9'b0, band};
    t_w    = {2'b0, thr};
    sum_w  = t_w + step;
    diff_w = t_w - step;
    servo_step = thr;
    if (c25 > hi25) begin
      servo_step = (sum_w > {2'b0, tmax}) ? tmax : sum_w[THRESH_BITS-1:0];
    end else if (lo25 < t25) begin
      servo_step = (t_w < ({2'b0, tmin} + step)) ? tmin : diff_w[THRESH_BITS-1:0];
    end
  endfunction

endpackage

// File: rtl/l1_servo_wb_master.sv
// rtl/l1_servo_wb_master.sv - single-transaction Wishbone classic engine with ack timeout
module l1_servo_wb_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [12:0] adr,
  input  logic [31:0] wdat,
  output logic        done,
  output logic        fail,
  output logic [31:0] rdat,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [12:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [12:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [31:0]   rdat_q, rdat_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Requests are only accepted while the bus is idle; done/fail pulse in the cycle cyc drops.
  always_comb begin
    cyc_d  = cyc_q;
    we_d   = we_q;
    adr_d  = adr_q;
    dat_d  = dat_q;
    rdat_d = rdat_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    fail_d = 1'b0;
    if (!cyc_q) begin
      if (req) begin
        cyc_d = 1'b1;
        we_d  = we;
        adr_d = adr;
        dat_d = wdat;
        cnt_d = '0;
      end
    end else if (wb_err_i) begin
      cyc_d  = 1'b0;
      fail_d = 1'b1;
    end else if (wb_ack_i) begin
      cyc_d  = 1'b0;
      done_d = 1'b1;
      if (!we_q) rdat_d = wb_dat_i;
    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
      cyc_d  = 1'b0;
      fail_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q  <= 1'b0;
      we_q   <= 1'b0;
      adr_q  <= '0;
      dat_q  <= '0;
      rdat_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      cyc_q  <= cyc_d;
      we_q   <= we_d;
      adr_q  <= adr_d;
      dat_q  <= dat_d;
      rdat_q <= rdat_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      fail_q <= fail_d;
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign rdat     = rdat_q;
  assign done     = done_q;
  assign fail     = fail_q;

endmodule

// File: rtl/l1_threshold_servo.sv
// rtl/l1_threshold_servo.sv - per-pass read of beam scalers, threshold stepping, write-back and commit
module l1_threshold_servo
  import l1_servo_pkg::*;
#(
  parameter int          NBEAMS      = 2,
  parameter int          THRESH_BITS = l1_servo_pkg::THRESH_BITS,
  parameter thresh_t     INIT_THRESH = 18'd4000,
  parameter thresh_t     THRESH_MIN  = 18'd100,
  parameter thresh_t     THRESH_MAX  = 18'd262143,
  parameter int          STEP        = 16,
  parameter logic [12:0] SCALER_BASE = l1_servo_pkg::SCALER_BASE,
  parameter logic [12:0] THRESH_BASE = l1_servo_pkg::THRESH_BASE,
  parameter logic [12:0] UPDATE_ADDR = l1_servo_pkg::UPDATE_ADDR,
  parameter int          TIMEOUT     = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        enable_i,
  input  logic        count_done_i,
  input  logic [23:0] target_i,
  input  logic [15:0] deadband_i,
  output logic        m_wb_cyc_o,
  output logic        m_wb_stb_o,
  output logic        m_wb_we_o,
  output logic [12:0] m_wb_adr_o,
  output logic [31:0] m_wb_dat_o,
  output logic [3:0]  m_wb_sel_o,
  input  logic [31:0] m_wb_dat_i,
  input  logic        m_wb_ack_i,
  input  logic        m_wb_err_i,
  output logic        busy_o,
  output logic        error_o,
  output logic        overrun_o,
  output logic [15:0] pass_count_o
);

  localparam int BW = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
  localparam logic [THRESH_BITS+1:0] STEP_W = (THRESH_BITS + 2)'(STEP);

  state_e        state_q, state_d;
  logic [BW-1:0] b_q, b_d;
  logic          issued_q, issued_d;
  logic          pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic          error_q, error_d;
  logic          en_q;
  logic [15:0]   pass_q, pass_d;
  thresh_t       new_thr_q, new_thr_d;
  thresh_t       thr_q [NBEAMS];
  thresh_t       thr_d [NBEAMS];

  logic        req;
  logic        req_we;
  logic [12:0] req_adr;
  logic [31:0] req_wdat;
  logic        done;
  logic        fail;
  logic [31:0] rdat;
  logic [12:0] beam_ofs;
  logic        unused_rdat_hi;

  assign beam_ofs       = {{(11 - BW){1'b0}}, b_q, 2'b00};
  assign unused_rdat_hi = ^rdat[31:24];

  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    issued_d  = issued_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    error_d   = error_q;
    pass_d    = pass_q;
    new_thr_d = new_thr_q;
    thr_d     = thr_q;
    req       = 1'b0;
    req_we    = 1'b0;
    req_adr   = '0;
    req_wdat  = '0;

    if (enable_i && !en_q) error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pending_q && enable_i) begin
          state_d   = S_RD_SCAL;
          b_d       = '0;
          pending_d = 1'b0;
        end
      end
      S_RD_SCAL: begin
        req     = !issued_q;
        req_adr = SCALER_BASE + beam_ofs;
        if (fail)      state_d = S_ABORT;
        else if (done) state_d = enable_i ? S_CALC : S_IDLE;
      end
      S_CALC: begin
        new_thr_d = servo_step(thr_q[b_q], rdat[23:0], target_i, deadband_i,
                               STEP_W, THRESH_MIN, THRESH_MAX);
        state_d   = enable_i ? S_WR_THR : S_IDLE;
      end
      S_WR_THR: begin
        req      = !issued_q;
        req_we   = 1'b1;
        req_adr  = THRESH_BASE + beam_ofs;
        req_wdat = {{(32 - THRESH_BITS){1'b0}}, new_thr_q};
        if (fail) begin
          state_d = S_ABORT;
        end else if (done) begin
          thr_d[b_q] = new_thr_q;
          state_d    = enable_i ? S_NEXT : S_IDLE;
        end
      end
      S_NEXT: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (b_q == BW'(NBEAMS - 1)) begin
          state_d = S_WR_UPD;
        end else begin
          b_d     = b_q + 1'b1;
          state_d = S_RD_SCAL;
        end
      end
      S_WR_UPD: begin
        req      = !issued_q;
        req_we   = 1'b1;
        req_adr  = UPDATE_ADDR;
        req_wdat = 32'h1;
        if (fail) begin
          state_d = S_ABORT;
        end else if (done) begin
          pass_d  = pass_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ABORT: begin
        error_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (req) issued_d = 1'b1;
    if (done || fail) issued_d = 1'b0;

    // A pulse that finds one already waiting is dropped and flagged.
    if (count_done_i && enable_i) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      b_q       <= '0;
      issued_q  <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      error_q   <= 1'b0;
      en_q      <= 1'b0;
      pass_q    <= '0;
      new_thr_q <= INIT_THRESH;
      for (int i = 0; i < NBEAMS; i++) thr_q[i] <= INIT_THRESH;
    end else begin
      state_q   <= state_d;
      b_q       <= b_d;
      issued_q  <= issued_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      error_q   <= error_d;
      en_q      <= enable_i;
      pass_q    <= pass_d;
      new_thr_q <= new_thr_d;
      thr_q     <= thr_d;
    end
  end

  l1_servo_wb_master #(
    .TIMEOUT(TIMEOUT)
  ) u_wb_master (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .req      (req),
    .we       (req_we),
    .adr      (req_adr),
    .wdat     (req_wdat),
    .done     (done),
    .fail     (fail),
    .rdat     (rdat),
    .wb_cyc_o (m_wb_cyc_o),
    .wb_stb_o (m_wb_stb_o),
    .wb_we_o  (m_wb_we_o),
    .wb_adr_o (m_wb_adr_o),
    .wb_dat_o (m_wb_dat_o),
    .wb_dat_i (m_wb_dat_i),
    .wb_ack_i (m_wb_ack_i),
    .wb_err_i (m_wb_err_i)
  );

  assign m_wb_sel_o   = 4'hF;
  assign busy_o       = (state_q != S_IDLE);
  assign error_o      = error_q;
  assign overrun_o    = overrun_q;
  assign pass_count_o = pass_q;

endmodule

// File: tb/tb_l1_threshold_servo.sv
// tb/tb_l1_threshold_servo.sv - scoreboard bench for l1_threshold_servo with a behavioural threshold model
module tb_l1_threshold_servo;

  localparam int TMAX  = 4053;
  localparam int TMIN  = 100;
  localparam int STEPV = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        cd;
  logic [23:0] target;
  logic [15:0] band;
  logic        cyc, stb, we;
  logic [12:0] adr;
  logic [31:0] dat_o;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic        ack, err;
  logic        busy, error, overrun;
  logic [15:0] pcount;

  typedef struct {
    bit          we;
    logic [12:0] adr;
    logic [31:0] dat;
  } txn_t;

  txn_t        exp_q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  int          mthr[2] = '{4000, 4000};
  int          exp_pc  = 0;
  logic [31:0] scal_dat[2];
  int          wait_n  = 0;
  int          wcnt    = 0;
  bit          hang    = 0;
  bit          err_en  = 0;
  int          run     = 0;
  int          last_run = 0;

  always #5 clk = ~clk;

  l1_threshold_servo #(
    .THRESH_MAX(18'd4053)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .enable_i    (enable),
    .count_done_i(cd),
    .target_i    (target),
    .deadband_i  (band),
    .m_wb_cyc_o  (cyc),
    .m_wb_stb_o  (stb),
    .m_wb_we_o   (we),
    .m_wb_adr_o  (adr),
    .m_wb_dat_o  (dat_o),
    .m_wb_sel_o  (sel),
    .m_wb_dat_i  (dat_i),
    .m_wb_ack_i  (ack),
    .m_wb_err_i  (err),
    .busy_o      (busy),
    .error_o     (error),
    .overrun_o   (overrun),
    .pass_count_o(pcount)
  );

  // Slave: fixed wait states, optional hang on the beam-1 read, optional err on the commit.
  always @(posedge clk) begin
    if (cyc && stb && !ack) wcnt <= wcnt + 1;
    else                    wcnt <= 0;
  end
  assign ack   = cyc && stb && (wcnt >= wait_n) && !(hang && adr == 13'h0804);
  assign err   = ack && err_en && adr == 13'h1000;
  assign dat_i = adr[11] ? scal_dat[adr[2]] : 32'hDEAD_BEEF;

  task automatic check(string name, longint act, longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (cyc && stb) run++;
    else begin
      if (run != 0) last_run = run;
      run = 0;
    end
    if (cyc && stb && ack && !err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_txn_adr", adr, -1);
      end else begin
        txn_t t;
        t = exp_q.pop_front();
        check("txn_we", we, t.we);
        check("txn_adr", adr, t.adr);
        if (t.we) check("txn_wdat", dat_o, t.dat);
        check("txn_sel", sel, 4'hF);
      end
    end
  end

  function automatic int model_step(int thr, longint c, longint t, longint d);
    if (c > t + d) return (thr + STEPV > TMAX) ? TMAX : thr + STEPV;
    if (c + d < t) return (thr - STEPV < TMIN) ? TMIN : thr - STEPV;
    return thr;
  endfunction

  task automatic push_beam(int b, bit do_write);
    exp_q.push_back('{0, 13'(13'h0800 + 4 * b), 32'h0});
    if (do_write) begin
      mthr[b] = model_step(mthr[b], longint'(scal_dat[b][23:0]), longint'(target), longint'(band));
      exp_q.push_back('{1, 13'(4 * b), 32'(mthr[b])});
    end
  endtask

  task automatic push_pass();
    push_beam(0, 1);
    push_beam(1, 1);
    exp_q.push_back('{1, 13'h1000, 32'h1});
    exp_pc++;
  endtask

  task automatic pulse();
    @(negedge clk) cd = 1'b1;
    @(negedge clk) cd = 1'b0;
  endtask

  task automatic wait_pass(string name);
    int n;
    for (n = 0; n < 20 && !busy; n++) @(negedge clk);
    for (n = 0; n < 3000 && busy; n++) @(negedge clk);
    check(name, busy, 0);
  endtask

  task automatic set_scal(int c0, int c1);
    scal_dat[0] = {8'($urandom), 24'(c0)};
    scal_dat[1] = {8'($urandom), 24'(c1)};
  endtask

  task automatic run_pass(int c0, int c1, int w);
    set_scal(c0, c1);
    wait_n = w;
    push_pass();
    pulse();
    wait_pass("pass_end");
    check("pass_count", pcount, exp_pc);
    check("error_after_pass", error, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int c;
    int n;
    int base;
    rst = 1'b1; enable = 1'b0; cd = 1'b0; target = 24'd1000; band = 16'd100;
    scal_dat[0] = 0; scal_dat[1] = 0;
    repeat (3) @(negedge clk);
    check("rst_cyc", cyc, 0);
    check("rst_stb", stb, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_overrun", overrun, 0);
    check("rst_pass_count", pcount, 0);
    rst = 1'b0;
    @(negedge clk) enable = 1'b1;
    @(negedge clk);

    run_pass(1050, 1050, 0);
    run_pass(0, 50000, 0);

    for (int i = 0; i < 24; i++) begin
      target = 24'($urandom);
      band   = 16'($urandom);
      for (int b = 0; b < 2; b++) begin
        case ($urandom_range(0, 4))
          0: c = int'(target);
          1: c = int'(24'(target + band));
          2: c = int'(24'(target + band + 1));
          3: c = (target >= 24'(band)) ? int'(target - 24'(band)) : 0;
          default: c = int'($urandom & 32'hFFFFFF);
        endcase
        if (b == 0) scal_dat[0] = 32'(c); else scal_dat[1] = 32'(c);
      end
      run_pass(int'(scal_dat[0]), int'(scal_dat[1]), $urandom_range(0, 3));
    end

    target = 24'd1000; band = 16'd100;
    for (n = 0; n < 20 && mthr[1] < TMAX; n++) run_pass(1050, 50000, 0);
    run_pass(1050, 50000, 1);
    check("ceiling_model", mthr[1], TMAX);

    for (n = 0; n < 400 && mthr[0] > TMIN; n++) run_pass(0, 1050, 0);
    run_pass(0, 1050, 0);
    check("floor_model", mthr[0], TMIN);
    check("overrun_quiet", overrun, 0);

    // Beam-1 read never acknowledged.
    set_scal(0, 50000);
    wait_n = 0; hang = 1;
    push_beam(0, 1);
    exp_q.push_back('{0, 13'h0804, 32'h0});
    pulse();
    for (n = 0; n < 2000 && !error; n++) @(negedge clk);
    check("timeout_error", error, 1);
    check("timeout_stb_cycles", last_run, 255);
    check("timeout_pending_read", exp_q.size(), 1);
    void'(exp_q.pop_front());
    @(negedge clk);
    check("timeout_busy", busy, 0);
    check("timeout_pass_count", pcount, exp_pc);
    hang = 0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("error_sticky", error, 1);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    check("error_cleared", error, 0);

    // Bus error coinciding with ack on the commit.
    err_en = 1;
    set_scal(1050, 1050);
    push_beam(0, 1);
    push_beam(1, 1);
    pulse();
    wait_pass("err_pass_end");
    check("err_error", error, 1);
    check("err_pass_count", pcount, exp_pc);
    check("err_queue", exp_q.size(), 0);
    err_en = 0;
    enable = 1'b0;
    @(negedge clk) enable = 1'b1;
    @(negedge clk);

    // Enable dropped while the beam-0 write is waiting.
    set_scal(50000, 0);
    wait_n = 3;
    push_beam(0, 1);
    pulse();
    for (n = 0; n < 100 && !(cyc && we); n++) @(negedge clk);
    check("drop_saw_write", cyc && we, 1);
    enable = 1'b0;
    for (n = 0; n < 100 && busy; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("drop_busy", busy, 0);
    check("drop_error", error, 0);
    check("drop_pass_count", pcount, exp_pc);
    check("drop_queue", exp_q.size(), 0);
    enable = 1'b1;
    @(negedge clk);

    // Two pulses during a pass: one pending, one overrun.
    set_scal(0, 50000);
    wait_n = 0;
    base = exp_pc;
    push_pass();
    push_pass();
    pulse();
    for (n = 0; n < 20 && !busy; n++) @(negedge clk);
    pulse();
    pulse();
    for (n = 0; n < 300 && int'(pcount) != base + 2; n++) @(negedge clk);
    repeat (60) @(negedge clk);
    check("overrun_flag", overrun, 1);
    check("overrun_pass_count", pcount, base + 2);
    check("overrun_busy", busy, 0);
    check("overrun_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
